count_checker: RTL

//   Receive-side monitor for the free-running counter output. Samples a

---
 rtl/count_checker.sv | 99 +++++++++
 1 files changed

// File: rtl/count_checker.sv
// Receive-side monitor for a free-running counter: locks onto a +1 sequence
// and then flags, counts and reports every sample that breaks it.
module count_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 mismatch,
  output logic                 wrap,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  localparam logic [3:0] LockRun    = 4'(LOCK_CNT);
  // A single consistent sample is enough to lock when LOCK_CNT is 1.
  localparam logic       SeedLocked = (LOCK_CNT == 1);
  localparam state_e     SeedState  = SeedLocked ? StLocked : StAcquire;

  state_e               state;
  logic [3:0]           run;
  logic                 match;
  logic [WIDTH-1:0]     seed;
  logic [WIDTH-1:0]     next_exp;
  logic [ERR_WIDTH-1:0] err_sat;

  always_comb begin
    match    = (count_in == expected);
    seed     = count_in + WIDTH'(1);
    next_exp = expected + WIDTH'(1);
    err_sat  = (err_count == '1) ? err_count : err_count + ERR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      run       <= 4'd0;
      locked    <= 1'b0;
      expected  <= '0;
      mismatch  <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      mismatch <= 1'b0;
      wrap     <= 1'b0;
      if (en) begin
        unique case (state)
          StIdle: begin
            expected <= seed;
            run      <= 4'd1;
            state    <= SeedState;
            locked   <= SeedLocked;
          end
          StAcquire: begin
            if (match) begin
              expected <= next_exp;
              run      <= run + 4'd1;
              if (run + 4'd1 == LockRun) begin
                state  <= StLocked;
                locked <= 1'b1;
              end
            end else begin
              // Reseed silently: errors only count once locked.
              expected <= seed;
              run      <= 4'd1;
            end
          end
          StLocked: begin
            if (match) begin
              expected <= next_exp;
              wrap     <= (count_in == '1);
            end else begin
              mismatch  <= 1'b1;
              err_count <= err_sat;
              expected  <= seed;
              run       <= 4'd1;
              state     <= SeedState;
              locked    <= SeedLocked;
            end
          end
          default: begin
            state  <= StIdle;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear has priority over a same-cycle increment.
      if (clr_err) err_count <= '0;
    end
  end

endmodule
